// File: rtl/cmd_rsp_read.sv
// SD CMD-line response receiver: waits for the card's start bit (Ncr timeout),
// deserialises an R1/R3/R6/R7 (48-bit) or R2 (136-bit) frame and checks it.
module cmd_rsp_read #(
  parameter int unsigned TimeoutCycles = 64
) (
  input  logic         sd_freq_clk_i,
  input  logic         rst_ni,
  input  logic         cmd_i,
  input  logic         start_listen_i,
  input  logic         long_rsp_i,
  input  logic         check_crc_i,
  input  logic         check_index_i,
  input  logic [5:0]   cmd_nr_i,
  output logic [119:0] rsp_o,
  output logic         rsp_done_o,
  output logic         busy_o,
  output logic         timeout_err_o,
  output logic         crc_err_o,
  output logic         end_bit_err_o,
  output logic         index_err_o
);

  localparam int unsigned TW = $clog2(TimeoutCycles + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_START,
    RECEIVE,
    DONE
  } state_e;

  state_e         state_q, state_d;
  logic [TW-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [7:0]     bit_cnt_q, bit_cnt_d;
  logic           long_q, long_d;
  logic           chk_crc_q, chk_crc_d;
  logic           chk_idx_q, chk_idx_d;
  logic [5:0]     cmd_nr_q, cmd_nr_d;
  logic [6:0]     crc_q, crc_d;
  logic [6:0]     crc_rx_q, crc_rx_d;
  logic [5:0]     idx_q, idx_d;
  logic           tx_q, tx_d;
  logic [119:0]   rsp_q, rsp_d;
  logic           tmo_err_q, tmo_err_d;
  logic           crc_err_q, crc_err_d;
  logic           eb_err_q, eb_err_d;
  logic           idx_err_q, idx_err_d;

  logic [7:0] last_idx;
  logic [7:0] bit_idx;
  logic [7:0] crc_top;
  logic [7:0] rsp_top;
  logic [7:0] tx_idx;
  logic       crc_fb;
  logic [6:0] crc_next;

  // Frame bit index counts down from N-1; the start bit is consumed in WAIT_START.
  always_comb begin
    last_idx = long_q ? 8'd135 : 8'd47;
    bit_idx  = last_idx - bit_cnt_q;
    crc_top  = long_q ? 8'd127 : 8'd46;
    rsp_top  = long_q ? 8'd127 : 8'd39;
    tx_idx   = long_q ? 8'd134 : 8'd46;
    crc_fb   = cmd_i ^ crc_q[6];
    crc_next = {crc_q[5:0], 1'b0} ^ (crc_fb ? 7'h09 : 7'h00);
  end

  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = tmo_cnt_q;
    bit_cnt_d = bit_cnt_q;
    long_d    = long_q;
    chk_crc_d = chk_crc_q;
    chk_idx_d = chk_idx_q;
    cmd_nr_d  = cmd_nr_q;
    crc_d     = crc_q;
    crc_rx_d  = crc_rx_q;
    idx_d     = idx_q;
    tx_d      = tx_q;
    rsp_d     = rsp_q;
    tmo_err_d = tmo_err_q;
    crc_err_d = crc_err_q;
    eb_err_d  = eb_err_q;
    idx_err_d = idx_err_q;

    unique case (state_q)
      IDLE: begin
        if (start_listen_i) begin
          state_d   = WAIT_START;
          long_d    = long_rsp_i;
          chk_crc_d = check_crc_i;
          chk_idx_d = check_index_i;
          cmd_nr_d  = cmd_nr_i;
          tmo_cnt_d = '0;
          bit_cnt_d = '0;
          crc_d     = '0;
          crc_rx_d  = '0;
          idx_d     = '0;
          tx_d      = 1'b0;
          rsp_d     = '0;
          tmo_err_d = 1'b0;
          crc_err_d = 1'b0;
          eb_err_d  = 1'b0;
          idx_err_d = 1'b0;
        end
      end

      WAIT_START: begin
        // A low sample always wins, even on the cycle the timeout would expire.
        if (!cmd_i) begin
          state_d   = RECEIVE;
          bit_cnt_d = 8'd1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
          if (tmo_cnt_q == TW'(TimeoutCycles - 1)) begin
            tmo_err_d = 1'b1;
            state_d   = DONE;
          end
        end
      end

      RECEIVE: begin
        bit_cnt_d = bit_cnt_q + 8'd1;
        if (bit_idx >= 8'd8 && bit_idx <= crc_top) begin
          crc_d = crc_next;
        end
        if (bit_idx >= 8'd1 && bit_idx <= 8'd7) begin
          crc_rx_d = {crc_rx_q[5:0], cmd_i};
        end
        if (!long_q && bit_idx >= 8'd40 && bit_idx <= 8'd45) begin
          idx_d = {idx_q[4:0], cmd_i};
        end
        if (bit_idx == tx_idx) begin
          tx_d = cmd_i;
        end
        if (bit_idx >= 8'd8 && bit_idx <= rsp_top) begin
          rsp_d = {rsp_q[118:0], cmd_i};
        end
        if (bit_cnt_q == last_idx) begin
          state_d   = DONE;
          crc_err_d = chk_crc_q && (crc_rx_q != crc_q);
          eb_err_d  = !cmd_i || tx_q;
          idx_err_d = chk_idx_q && !long_q && (idx_q != cmd_nr_q);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sd_freq_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      tmo_cnt_q <= '0;
      bit_cnt_q <= '0;
      long_q    <= 1'b0;
      chk_crc_q <= 1'b0;
      chk_idx_q <= 1'b0;
      cmd_nr_q  <= '0;
      crc_q     <= '0;
      crc_rx_q  <= '0;
      idx_q     <= '0;
      tx_q      <= 1'b0;
      rsp_q     <= '0;
      tmo_err_q <= 1'b0;
      crc_err_q <= 1'b0;
      eb_err_q  <= 1'b0;
      idx_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      long_q    <= long_d;
      chk_crc_q <= chk_crc_d;
      chk_idx_q <= chk_idx_d;
      cmd_nr_q  <= cmd_nr_d;
      crc_q     <= crc_d;
      crc_rx_q  <= crc_rx_d;
      idx_q     <= idx_d;
      tx_q      <= tx_d;
      rsp_q     <= rsp_d;
      tmo_err_q <= tmo_err_d;
      crc_err_q <= crc_err_d;
      eb_err_q  <= eb_err_d;
      idx_err_q <= idx_err_d;
    end
  end

  assign rsp_o         = rsp_q;
  assign rsp_done_o    = (state_q == DONE);
  assign busy_o        = (state_q != IDLE);
  assign timeout_err_o = tmo_err_q;
  assign crc_err_o     = crc_err_q;
  assign end_bit_err_o = eb_err_q;
  assign index_err_o   = idx_err_q;

endmodule

// File: tb/tb_cmd_rsp_read.sv
// Scoreboard bench for cmd_rsp_read: driver pushes expected results at arm time,
// a negedge monitor pops and compares whenever rsp_done_o is seen.
module tb_cmd_rsp_read;

  localparam int T = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd = 1'b1;
  logic         start = 1'b0;
  logic         lng = 1'b0;
  logic         ccrc = 1'b0;
  logic         cidx = 1'b0;
  logic [5:0]   nr = '0;
  logic [119:0] rsp;
  logic         done, busy, tmo_err, crc_err, eb_err, idx_err;

  cmd_rsp_read #(.TimeoutCycles(T)) dut (
    .sd_freq_clk_i (clk),
    .rst_ni        (rst_n),
    .cmd_i         (cmd),
    .start_listen_i(start),
    .long_rsp_i    (lng),
    .check_crc_i   (ccrc),
    .check_index_i (cidx),
    .cmd_nr_i      (nr),
    .rsp_o         (rsp),
    .rsp_done_o    (done),
    .busy_o        (busy),
    .timeout_err_o (tmo_err),
    .crc_err_o     (crc_err),
    .end_bit_err_o (eb_err),
    .index_err_o   (idx_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string        name;
    logic [119:0] rsp;
    logic         tmo, crc, eb, idx;
    int           cyc;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference CRC7 by polynomial long division (message followed by 7 zeros).
  function automatic logic [6:0] crc7_div(input logic [119:0] msg, input int n);
    logic [126:0] r;
    r = {msg, 7'b0};
    for (int i = n + 6; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic logic [135:0] mk48(input logic tx, input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] m;
    m = {1'b0, tx, idx, arg};
    return {88'b0, m, crc7_div({80'b0, m}, 40), 1'b1};
  endfunction

  function automatic logic [135:0] mk136(input logic [119:0] p);
    return {8'b0011_1111, p, crc7_div(p, 120), 1'b1};
  endfunction

  // Monitor
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (prev_done) chk("done_pulse_width", 128'(done), 128'(0));
    prev_done = done;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got rsp_done_o=1 at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_rsp"},   128'(rsp),     128'(e.rsp));
        chk({e.name, "_tmo"},   128'(tmo_err), 128'(e.tmo));
        chk({e.name, "_crc"},   128'(crc_err), 128'(e.crc));
        chk({e.name, "_eb"},    128'(eb_err),  128'(e.eb));
        chk({e.name, "_idx"},   128'(idx_err), 128'(e.idx));
        chk({e.name, "_busy"},  128'(busy),    128'(1));
        chk({e.name, "_cycle"}, 128'(cyc),     128'(e.cyc));
      end
    end
  end

  int arm_neg;

  task automatic arm(input logic l, input logic cc, input logic ci, input logic [5:0] n);
    @(negedge clk);
    lng = l; ccrc = cc; cidx = ci; nr = n; start = 1'b1;
    arm_neg = cyc;
    @(negedge clk);
    start = 1'b0;
    lng = ~l; ccrc = ~cc; cidx = ~ci; nr = ~n;
  endtask

  task automatic push(input string name, input logic [119:0] r, input logic t, input logic c,
                      input logic eb, input logic ix, input int dc);
    exp_t e;
    e.name = name; e.rsp = r; e.tmo = t; e.crc = c; e.eb = eb; e.idx = ix; e.cyc = dc;
    sb.push_back(e);
  endtask

  task automatic send(input logic [135:0] f, input int n, input int idle, input int rearm_at,
                      input int stop_at);
    for (int i = 0; i < idle; i++) begin
      cmd = 1'b1;
      @(negedge clk);
    end
    for (int b = 0; b < n && b < stop_at; b++) begin
      cmd = f[n-1-b];
      if (b == rearm_at) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    cmd = 1'b1;
  endtask

  task automatic run(input string name, input logic [135:0] f, input logic l, input logic cc,
                     input logic ci, input logic [5:0] n, input int idle, input int rearm_at,
                     input logic [119:0] ersp, input logic ecrc, input logic eeb, input logic eidx);
    int len;
    len = l ? 136 : 48;
    arm(l, cc, ci, n);
    push(name, ersp, 1'b0, ecrc, eeb, eidx, arm_neg + 1 + idle + len);
    send(f, len, idle, rearm_at, 1000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200us");
    $fatal(1);
  end

  initial begin
    logic [135:0] f;
    logic [119:0] cid;
    cid = 120'h035344_53443332_30109876_54321001;

    repeat (3) @(negedge clk);
    chk("reset_rsp",  128'(rsp),  128'(0));
    chk("reset_done", 128'(done), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_flags", 128'({tmo_err, crc_err, eb_err, idx_err}), 128'(0));
    rst_n = 1'b1;

    run("r1_clean", mk48(1'b0, 6'd17, 32'h0000_0900), 1'b0, 1'b1, 1'b1, 6'd17, 5, -1,
        120'h900, 1'b0, 1'b0, 1'b0);

    arm(1'b0, 1'b1, 1'b1, 6'd17);
    push("timeout", '0, 1'b1, 1'b0, 1'b0, 1'b0, arm_neg + T + 1);
    send('0, 0, T, -1, 0);
    repeat (3) @(negedge clk);
    chk("timeout_hold", 128'(tmo_err), 128'(1));
    chk("idle_after_done", 128'(busy), 128'(0));

    run("start_last", mk48(1'b0, 6'd17, 32'h1234_5678), 1'b0, 1'b1, 1'b1, 6'd17, T - 1, -1,
        120'h1234_5678, 1'b0, 1'b0, 1'b0);

    run("bad_index", mk48(1'b0, 6'h12, 32'h0000_0900), 1'b0, 1'b1, 1'b1, 6'd17, 2, -1,
        120'h900, 1'b0, 1'b0, 1'b1);

    f = mk48(1'b0, 6'd17, 32'h0000_0900);
    f[3] = ~f[3];
    run("bad_crc", f, 1'b0, 1'b1, 1'b1, 6'd17, 2, -1, 120'h900, 1'b1, 1'b0, 1'b0);

    f = mk48(1'b0, 6'd17, 32'h0000_0900);
    f[0] = 1'b0;
    run("bad_end", f, 1'b0, 1'b1, 1'b1, 6'd17, 2, -1, 120'h900, 1'b0, 1'b1, 1'b0);

    run("bad_tx", mk48(1'b1, 6'd17, 32'h0000_0900), 1'b0, 1'b1, 1'b1, 6'd17, 2, -1,
        120'h900, 1'b0, 1'b1, 1'b0);

    f = mk48(1'b0, 6'h12, 32'h0000_0900);
    f[3] = ~f[3];
    f[0] = 1'b0;
    run("all_bad", f, 1'b0, 1'b1, 1'b1, 6'd17, 2, -1, 120'h900, 1'b1, 1'b1, 1'b1);
    run("all_bad_nochk", f, 1'b0, 1'b0, 1'b0, 6'd17, 2, -1, 120'h900, 1'b0, 1'b1, 1'b0);

    run("r2_cid", mk136(cid), 1'b1, 1'b1, 1'b1, 6'd2, 4, -1, cid, 1'b0, 1'b0, 1'b0);

    run("rearm_ignored", mk48(1'b0, 6'd17, 32'hCAFE_0001), 1'b0, 1'b1, 1'b1, 6'd17, 2, 10,
        120'hCAFE_0001, 1'b0, 1'b0, 1'b0);

    arm(1'b0, 1'b1, 1'b1, 6'd17);
    send(mk48(1'b0, 6'd17, 32'hFFFF_FFFF), 48, 3, -1, 20);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_rsp",  128'(rsp),  128'(0));
    chk("midreset_busy", 128'(busy), 128'(0));
    chk("midreset_done", 128'(done), 128'(0));
    chk("midreset_flags", 128'({tmo_err, crc_err, eb_err, idx_err}), 128'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run("after_reset", mk48(1'b0, 6'd17, 32'h0000_0900), 1'b0, 1'b1, 1'b1, 6'd17, 0, -1,
        120'h900, 1'b0, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 128'(sb.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
